// File: rtl/splitmix_pkg.sv
// splitmix_pkg: shared constants and state encoding for the SplitMix64 seeder
package splitmix_pkg;
  localparam logic [63:0] SM_GAMMA_DEF = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] SM_MUL1 = 64'hBF58476D1CE4E5B9;
  localparam logic [63:0] SM_MUL2 = 64'h94D049BB133111EB;
  localparam logic [5:0] SM_SH1 = 6'd30;
  localparam logic [5:0] SM_SH2 = 6'd27;
  localparam logic [5:0] SM_SH3 = 6'd31;
  typedef enum logic [3:0] {
    IDLE = 4'd0,
    A0 = 4'd1,
    M10 = 4'd2,
    M20 = 4'd3,
    F0 = 4'd4,
    A1 = 4'd5,
    M11 = 4'd6,
    M21 = 4'd7,
    F1 = 4'd8
  } sm_state_e;
endpackage

// File: rtl/splitmix64_mix_step.sv
// splitmix64_mix_step: one xor-shift-multiply mixing round, product truncated to 64 bits
module splitmix64_mix_step (
  input  logic [63:0] z,
  input  logic [5:0]  sh,
  input  logic [63:0] mul,
  output logic [63:0] y
);
  assign y = (z ^ (z >> sh)) * mul;
endmodule

// File: rtl/splitmix64_seeder.sv
// splitmix64_seeder: expands a 64-bit seed into a 128-bit xoroshiro128+ state via two SplitMix64 steps
module splitmix64_seeder
  import splitmix_pkg::*;
#(
  parameter logic [63:0] GAMMA = SM_GAMMA_DEF,
  parameter bit ZERO_GUARD = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         cont,
  input  logic [63:0]  seed_in,
  output logic         busy,
  output logic         seed_valid,
  output logic         prng_load,
  output logic [127:0] seed_out
);
  sm_state_e state, state_d;
  logic [63:0] x, z, word0, w, mix;
  logic [127:0] res, guarded;
  logic is_add, is_m1, is_m2;
  assign is_add = state == A0 || state == A1;
  assign is_m1 = state == M10 || state == M11;
  assign is_m2 = state == M20 || state == M21;
  assign w = z ^ (z >> SM_SH3);
  assign res = {word0, w};
  assign guarded = (ZERO_GUARD && res == '0) ? 128'h1 : res;
  assign prng_load = seed_valid;
  splitmix64_mix_step u_mix (
    .z(z),
    .sh(is_m1 ? SM_SH1 : SM_SH2),
    .mul(is_m1 ? SM_MUL1 : SM_MUL2),
    .y(mix)
  );
  // next state: wait in IDLE for start, then walk the eight compute states in order
  always_comb begin
    state_d = state;
    state_d = (state == IDLE) ? (start ? A0 : IDLE) :
              (state == F1) ? IDLE : sm_state_e'(state + 4'd1);
  end
  // state register and datapath; x survives between requests so cont can resume the stream
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      x <= '0;
      z <= '0;
      word0 <= '0;
      seed_out <= '0;
      busy <= 1'b0;
      seed_valid <= 1'b0;
    end else begin
      state <= state_d;
      seed_valid <= state == F1;
      if (state == IDLE && start) begin
        busy <= 1'b1;
        if (!cont) x <= seed_in;
      end
      if (is_add) begin
        x <= x + GAMMA;
        z <= x + GAMMA;
      end
      if (is_m1 || is_m2) z <= mix;
      if (state == F0) word0 <= w;
      if (state == F1) begin
        seed_out <= guarded;
        busy <= 1'b0;
      end
    end
endmodule

// File: tb/tb_splitmix64_seeder.sv
// tb_splitmix64_seeder: randomized checks of the seeder against a plain-arithmetic SplitMix64 model
module tb_splitmix64_seeder;
  localparam logic [63:0] GAMMA = 64'h9E3779B97F4A7C15;
  localparam logic [127:0] C2 = 128'hE220A8397B1DCDAF_6E789E6AA1B965F4;
  localparam logic [127:0] C3 = 128'h06C45D188009454F_F88BB8A8724C81EC;
  logic clk, rst_n, start, cont;
  logic [63:0] seed_in;
  logic busy, seed_valid, prng_load, busy_nz, valid_nz, load_nz;
  logic [127:0] seed_out, seed_out_nz;
  logic [63:0] mx;
  int n_chk, n_pass;
  splitmix64_seeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .seed_in(seed_in),
    .busy(busy), .seed_valid(seed_valid), .prng_load(prng_load), .seed_out(seed_out)
  );
  splitmix64_seeder #(.ZERO_GUARD(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .seed_in(seed_in),
    .busy(busy_nz), .seed_valid(valid_nz), .prng_load(load_nz), .seed_out(seed_out_nz)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  function automatic logic [63:0] sm_next();
    logic [63:0] t;
    mx = mx + GAMMA;
    t = mx;
    t = (t ^ (t >> 30)) * 64'hBF58476D1CE4E5B9;
    t = (t ^ (t >> 27)) * 64'h94D049BB133111EB;
    return t ^ (t >> 31);
  endfunction
  task automatic run_req(input logic [63:0] s, input bit c, input bit noise, output logic [127:0] r);
    logic [63:0] w0, w1;
    int lat, extra;
    bit busy_ok, held;
    if (!c) mx = s;
    w0 = sm_next();
    w1 = sm_next();
    seed_in = s;
    cont = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!seed_valid && lat < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      start = noise && (lat == 2 || lat == 4);
      if (start) begin
        seed_in = {$urandom, $urandom};
        cont = 1'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    r = seed_out;
    check("latency", 128'(lat), 128'd8);
    check("busy_high", {127'd0, busy_ok}, 128'd1);
    check("result", seed_out, {w0, w1});
    check("done_flags", {125'd0, busy, seed_valid, prng_load}, 128'b011);
    extra = 0;
    held = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (seed_valid) extra++;
      if (seed_out !== r) held = 1'b0;
    end
    check("no_extra_valid", 128'(extra), 128'd0);
    check("out_held", {127'd0, held}, 128'd1);
  endtask
  initial begin
    logic [127:0] r, exp;
    logic [63:0] w0, w1;
    int lat, vcnt;
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    start = 1'b0;
    cont = 1'b0;
    seed_in = '0;
    mx = '0;
    #3;
    check("rst_out", seed_out, 128'd0);
    check("rst_flags", {125'd0, busy, seed_valid, prng_load}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_busy", {127'd0, busy}, 128'd0);
    run_req(64'd0, 1'b0, 1'b0, r);
    check("t2_const", r, C2);
    run_req({$urandom, $urandom}, 1'b1, 1'b0, r);
    check("t3_const", r, C3);
    run_req(64'd0, 1'b0, 1'b1, r);
    check("t4_const", r, C2);
    seed_in = 64'h5;
    cont = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_out", seed_out, 128'd0);
    check("t5_rst_flags", {125'd0, busy, seed_valid, prng_load}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (seed_valid) vcnt++;
    end
    check("t5_no_valid", 128'(vcnt), 128'd0);
    mx = '0;
    run_req(64'd0, 1'b0, 1'b0, r);
    check("t5_const", r, C2);
    seed_in = '0;
    cont = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    cont = 1'b1;
    mx = '0;
    for (int k = 0; k < 3; k++) begin
      w0 = sm_next();
      w1 = sm_next();
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (!seed_valid && lat < 20);
      exp = (k == 0) ? C2 : (k == 1) ? C3 : {w0, w1};
      check("b2b_period", 128'(lat), (k == 0) ? 128'd8 : 128'd9);
      check("b2b_result", seed_out, exp);
      if (k == 0) check("xoro_first", 128'(seed_out[127:64] + seed_out[63:0]), 128'(w0 + w1));
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_req({$urandom, $urandom}, 1'($urandom), 1'($urandom), r);
    end
    force dut.z = '0;
    force dut.word0 = '0;
    force dut_nz.z = '0;
    force dut_nz.word0 = '0;
    seed_in = 64'h7;
    cont = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!seed_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("zg_latency", 128'(lat), 128'd8);
    check("zg_on", seed_out, 128'h1);
    check("zg_off", seed_out_nz, 128'h0);
    release dut.z;
    release dut.word0;
    release dut_nz.z;
    release dut_nz.word0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
